// File: rtl/pu_msp430_perbus_master.sv
`default_nettype none
// ============================================================================
// pu_msp430_perbus_master : turns valid/ready host requests into single
// MSP430 peripheral-bus accesses and returns the result on a response channel.
// Rev 1.0
// ============================================================================
module pu_msp430_perbus_master #(
  parameter int WAIT_CYCLES = 0,
  parameter int WCNT_W      = 4
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [WCNT_W-1:0] c_wait = WCNT_W'(WAIT_CYCLES);
  localparam logic [WCNT_W-1:0] c_one  = WCNT_W'(1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  logic [13:0]        addr_q, addr_d;
  logic [15:0]        din_q, din_d;
  logic               en_q, en_d;
  logic [1:0]         we_q, we_d;
  logic               wr_q, wr_d;
  logic               byte_q, byte_d;
  logic               a0_q, a0_d;
  logic               rvalid_q, rvalid_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               rerr_q, rerr_d;
  logic               rdy_q, rdy_d;

  function automatic logic [1:0] we_mask(input logic wr, input logic byt, input logic a0);
    if (!wr)  return 2'b00;
    if (!byt) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    en_d     = en_q;
    we_d     = we_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    a0_d     = a0_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_addr[15] || (!req_byte && req_addr[0])) begin
            // Rejected request: answer immediately, bus stays untouched.
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rdata_d  = 16'h0000;
            state_d  = S_RESP;
          end else begin
            addr_d  = req_addr[14:1];
            din_d   = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
            en_d    = 1'b1;
            cnt_d   = c_wait;
            wr_d    = req_write;
            byte_d  = req_byte;
            a0_d    = req_addr[0];
            if (c_wait == '0) we_d = we_mask(req_write, req_byte, req_addr[0]);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_one;
          // Strobe is registered, so it is raised one edge before the final cycle.
          if (cnt_q == c_one) we_d = we_mask(wr_q, byte_q, a0_q);
        end else begin
          en_d     = 1'b0;
          we_d     = 2'b00;
          rvalid_d = 1'b1;
          rerr_d   = 1'b0;
          if (wr_q)        rdata_d = 16'h0000;
          else if (byte_q) rdata_d = {8'h00, a0_q ? per_dout[15:8] : per_dout[7:0]};
          else             rdata_d = per_dout;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= 14'h0000;
      din_q    <= 16'h0000;
      en_q     <= 1'b0;
      we_q     <= 2'b00;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      a0_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 16'h0000;
      rerr_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      en_q     <= en_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
      byte_q   <= byte_d;
      a0_q     <= a0_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rdy_q    <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign per_addr  = addr_q;
  assign per_din   = din_q;
  assign per_en    = en_q;
  assign per_we    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_msp430_perbus_master.sv
`default_nettype none
// ============================================================================
// tb_pu_msp430_perbus_master : two instances (0 and 3 wait states) driven with
// host traffic and compared against a byte-addressed memory model.
// Rev 1.0
// ============================================================================
module tb_pu_msp430_perbus_master;

  logic mclk = 1'b0;
  logic puc_rst_n;
  always #5 mclk = ~mclk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_addr  [2];
  logic        req_write [2];
  logic        req_byte  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [13:0] per_addr  [2];
  logic [15:0] per_din   [2];
  logic        per_en    [2];
  logic [1:0]  per_we    [2];
  logic [15:0] per_dout  [2];

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] ref_mem [2][256];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    logic [15:0] slv [128] = '{default: 16'h0000};

    pu_msp430_perbus_master #(
      .WAIT_CYCLES(g == 0 ? 0 : 3),
      .WCNT_W     (4)
    ) u_dut (
      .mclk     (mclk),
      .puc_rst_n(puc_rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_write(req_write[g]),
      .req_byte (req_byte[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .per_addr (per_addr[g]),
      .per_din  (per_din[g]),
      .per_en   (per_en[g]),
      .per_we   (per_we[g]),
      .per_dout (per_dout[g])
    );

    // Simple register-slave: combinational read, byte-lane writes on the edge.
    assign per_dout[g] = per_en[g] ? slv[per_addr[g][6:0]] : 16'h0000;
    always @(posedge mclk) begin
      if (per_en[g] && per_we[g][0]) slv[per_addr[g][6:0]][7:0]  <= per_din[g][7:0];
      if (per_en[g] && per_we[g][1]) slv[per_addr[g][6:0]][15:8] <= per_din[g][15:8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int k, input string s);
    return $sformatf("d%0d.%s", k, s);
  endfunction

  function automatic int wk(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] ref_word(input int k, input logic [15:0] a);
    return {ref_mem[k][{a[7:1], 1'b1}], ref_mem[k][{a[7:1], 1'b0}]};
  endfunction

  task automatic do_txn(input int k, input logic [15:0] a, input logic wr, input logic byt,
                        input logic [15:0] wd, input int hold);
    logic        err;
    logic [1:0]  exp_we;
    logic [15:0] exp_rd, exp_din, exp_q;
    int en_cnt, we_cnt, we_cyc, rsp_cyc;
    err     = a[15] | (~byt & a[0]);
    exp_we  = !wr ? 2'b00 : (!byt ? 2'b11 : (a[0] ? 2'b10 : 2'b01));
    exp_din = byt ? {wd[7:0], wd[7:0]} : wd;
    exp_rd  = byt ? {8'h00, ref_mem[k][a[7:0]]} : ref_word(k, a);
    if (wr || err) exp_rd = 16'h0000;

    @(negedge mclk);
    check_eq(tg(k, "req_ready_idle"), req_ready[k], 1);
    req_valid[k] = 1'b1; req_addr[k] = a; req_write[k] = wr;
    req_byte[k]  = byt;  req_wdata[k] = wd;
    rsp_ready[k] = (hold == 0);
    @(posedge mclk); #1;
    req_valid[k] = 1'b0;

    en_cnt = 0; we_cnt = 0; we_cyc = 0; rsp_cyc = 0;
    for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
      @(negedge mclk);
      if (per_en[k]) begin
        en_cnt++;
        check_eq(tg(k, "per_addr"), per_addr[k], a[14:1]);
        if (wr) check_eq(tg(k, "per_din"), per_din[k], exp_din);
      end else begin
        check_eq(tg(k, "we_without_en"), per_we[k], 0);
      end
      if (per_we[k] != 2'b00) begin
        we_cnt++;
        we_cyc = c;
        check_eq(tg(k, "per_we"), per_we[k], exp_we);
      end
      if (rsp_valid[k]) rsp_cyc = c;
    end
    if (rsp_cyc == 0) begin
      check_eq(tg(k, "rsp_timeout"), 0, 1);
      rsp_ready[k] = 1'b1;
      return;
    end
    check_eq(tg(k, "latency"), rsp_cyc, err ? 1 : wk(k) + 2);
    check_eq(tg(k, "en_cycles"), en_cnt, err ? 0 : wk(k) + 1);
    check_eq(tg(k, "we_cycles"), we_cnt, (wr && !err) ? 1 : 0);
    if (we_cnt != 0) check_eq(tg(k, "we_final_cycle"), we_cyc, wk(k) + 1);
    check_eq(tg(k, "rsp_err"), rsp_err[k], err);
    check_eq(tg(k, "rsp_rdata"), rsp_rdata[k], exp_rd);
    if (wr && !err) begin
      if (byt) ref_mem[k][a[7:0]] = wd[7:0];
      else begin
        ref_mem[k][{a[7:1], 1'b0}] = wd[7:0];
        ref_mem[k][{a[7:1], 1'b1}] = wd[15:8];
      end
    end

    if (hold > 0) begin
      // Backpressure with a competing request that must stay pending.
      req_valid[k] = 1'b1; req_addr[k] = 16'h0080; req_write[k] = 1'b0; req_byte[k] = 1'b0;
      exp_q = ref_word(k, 16'h0080);
      for (int d = 0; d < hold; d++) begin
        check_eq(tg(k, "hold_valid"), rsp_valid[k], 1);
        check_eq(tg(k, "hold_rdata"), rsp_rdata[k], exp_rd);
        check_eq(tg(k, "hold_err"), rsp_err[k], err);
        check_eq(tg(k, "hold_ready"), req_ready[k], 0);
        check_eq(tg(k, "hold_no_en"), per_en[k], 0);
        @(negedge mclk);
      end
      rsp_ready[k] = 1'b1;
      @(negedge mclk);
      check_eq(tg(k, "release_valid"), rsp_valid[k], 0);
      check_eq(tg(k, "release_ready"), req_ready[k], 1);
      @(posedge mclk); #1;
      req_valid[k] = 1'b0;
      @(negedge mclk);
      check_eq(tg(k, "queued_en"), per_en[k], 1);
      for (int c = 0; c < 20 && !rsp_valid[k]; c++) @(negedge mclk);
      check_eq(tg(k, "queued_valid"), rsp_valid[k], 1);
      check_eq(tg(k, "queued_rdata"), rsp_rdata[k], exp_q);
      @(negedge mclk);
    end else begin
      @(negedge mclk);
      check_eq(tg(k, "done_valid"), rsp_valid[k], 0);
      check_eq(tg(k, "done_ready"), req_ready[k], 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int k;
    puc_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = 16'h0000; req_write[i] = 1'b0;
      req_byte[i]  = 1'b0; req_wdata[i] = 16'h0000; rsp_ready[i] = 1'b1;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = 8'h00;
    end
    repeat (3) @(negedge mclk);
    puc_rst_n = 1'b1;
    @(negedge mclk);
    for (int i = 0; i < 2; i++) begin
      check_eq(tg(i, "rst_per_en"), per_en[i], 0);
      check_eq(tg(i, "rst_per_we"), per_we[i], 0);
      check_eq(tg(i, "rst_per_addr"), per_addr[i], 0);
      check_eq(tg(i, "rst_per_din"), per_din[i], 0);
      check_eq(tg(i, "rst_rsp_valid"), rsp_valid[i], 0);
      check_eq(tg(i, "rst_rsp_rdata"), rsp_rdata[i], 0);
      check_eq(tg(i, "rst_rsp_err"), rsp_err[i], 0);
      check_eq(tg(i, "rst_req_ready"), req_ready[i], 1);
    end

    do_txn(0, 16'h0090, 1'b1, 1'b0, 16'h5AA5, 0);
    do_txn(0, 16'h0090, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(0, 16'h0093, 1'b1, 1'b1, 16'h003C, 0);
    do_txn(0, 16'h0093, 1'b0, 1'b1, 16'h0000, 0);
    do_txn(0, 16'h0092, 1'b0, 1'b1, 16'h0000, 0);
    do_txn(0, 16'h0091, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(0, 16'h8000, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(1, 16'h0090, 1'b1, 1'b0, 16'hC3E1, 0);
    do_txn(1, 16'h0090, 1'b0, 1'b0, 16'h0000, 10);

    for (int i = 0; i < 120; i++) begin
      k = i % 2;
      if ($urandom_range(0, 7) == 0) a = {1'b1, 15'($urandom)};
      else                           a = 16'h0080 + 16'($urandom_range(0, 127));
      do_txn(k, a, 1'($urandom), 1'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Reset in the middle of a wait-stated write: it must vanish without a trace.
    @(negedge mclk);
    req_valid[1] = 1'b1; req_addr[1] = 16'h00A0; req_write[1] = 1'b1;
    req_byte[1]  = 1'b0; req_wdata[1] = ~ref_word(1, 16'h00A0); rsp_ready[1] = 1'b1;
    @(posedge mclk); #1;
    req_valid[1] = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    check_eq(tg(1, "pre_rst_en"), per_en[1], 1);
    #2 puc_rst_n = 1'b0;
    #1;
    check_eq(tg(1, "async_rst_en"), per_en[1], 0);
    check_eq(tg(1, "async_rst_we"), per_we[1], 0);
    check_eq(tg(1, "async_rst_valid"), rsp_valid[1], 0);
    @(negedge mclk);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge mclk);
      check_eq(tg(1, "post_rst_no_rsp"), rsp_valid[1], 0);
      check_eq(tg(1, "post_rst_no_en"), per_en[1], 0);
    end
    check_eq(tg(1, "post_rst_ready"), req_ready[1], 1);
    do_txn(1, 16'h00A0, 1'b0, 1'b0, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
